// File: rtl/tff_edge_meter.sv
// tff_edge_meter: measures the toggle activity of a T flip-flop output.
// q_in is synchronised into the clk domain. Its rising and falling edges are
// counted over a programmable window of clk cycles. The two counts and a
// saturation flag are then offered through a valid/ready result handshake.
module tff_edge_meter #(
    parameter int unsigned WIN_W       = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_rise,
    output logic [CNT_W-1:0] cnt_fall,
    output logic             overflow,
    output logic             res_valid,
    input  logic             res_ready
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in the range 2..4");
    end

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StMeas,
        StHold
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [CNT_W-1:0]       rise_q, rise_d;
    logic [CNT_W-1:0]       fall_q, fall_d;
    logic                   ovf_q, ovf_d;

    logic q_s;
    logic rise;
    logic fall;
    logic accept;
    logic meas;

    // ------------------------------------------------------------------
    // Synchroniser and edge detection
    // ------------------------------------------------------------------

    // Shift q_in through the synchroniser. The history flop tracks q_s in every
    // state, so no stale level difference can fake an edge at window start.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], q_in};
        hist_d = q_s;
    end

    assign q_s  = sync_q[SYNC_STAGES-1];
    assign rise = q_s & ~hist_q;
    assign fall = ~q_s & hist_q;

    // Synchroniser and history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // A start request is accepted only in IDLE. Start is ignored in MEAS and HOLD.
    assign accept = (state_q == StIdle) && start;
    assign meas   = (state_q == StMeas);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero-length window goes straight to HOLD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (win_len == '0) ? StHold : StMeas;
                end
            end
            StMeas: begin
                if (win_q == WIN_W'(1)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the state register only, so reset clears them at once.
    always_comb begin
        busy      = (state_q == StMeas);
        res_valid = (state_q == StHold);
    end

    // ------------------------------------------------------------------
    // Window counter and saturating edge counters
    // ------------------------------------------------------------------

    // Load the window length on accept. Count it down once per MEAS cycle.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            win_d = win_len;
        end else if (meas) begin
            win_d = win_q - WIN_W'(1);
        end
    end

    // The counters clear on accept and count only in MEAS. An increment attempted
    // at the saturation value sets the sticky overflow flag instead of wrapping.
    always_comb begin
        rise_d = rise_q;
        fall_d = fall_q;
        ovf_d  = ovf_q;
        if (accept) begin
            rise_d = '0;
            fall_d = '0;
            ovf_d  = 1'b0;
        end else if (meas) begin
            if (rise) begin
                if (rise_q == CntMax) begin
                    ovf_d = 1'b1;
                end else begin
                    rise_d = rise_q + CNT_W'(1);
                end
            end
            if (fall) begin
                if (fall_q == CntMax) begin
                    ovf_d = 1'b1;
                end else begin
                    fall_d = fall_q + CNT_W'(1);
                end
            end
        end
    end

    // Datapath registers. The counts hold their values in HOLD and in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            win_q  <= win_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt_rise = rise_q;
    assign cnt_fall = fall_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_tff_edge_meter.sv
// Testbench for tff_edge_meter. The driver issues measurement windows. When a
// window's stimulus is complete, it pushes the expected result into a queue.
// A separate monitor checks busy and res_valid every cycle, and checks each
// presented result against the front of the queue.
module tb_tff_edge_meter;

    localparam int unsigned WIN_W   = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SYNC    = 2;
    localparam int          MAXC    = 65536;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             q_in      = 1'b0;
    logic             start     = 1'b0;
    logic             res_ready = 1'b0;
    logic [WIN_W-1:0] win_len   = '0;
    logic             busy;
    logic [CNT_W-1:0] cnt_rise;
    logic [CNT_W-1:0] cnt_fall;
    logic             overflow;
    logic             res_valid;

    tff_edge_meter #(
        .WIN_W      (WIN_W),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .start    (start),
        .win_len  (win_len),
        .busy     (busy),
        .cnt_rise (cnt_rise),
        .cnt_fall (cnt_fall),
        .overflow (overflow),
        .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int f;
        int o;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // cyc is the index of the most recent rising clock edge.
    // samp[k] is the q_in level that the synchroniser captured at edge k.
    // It reads 0 while reset is held.
    int cyc = 0;
    bit samp[MAXC];
    bit rdy_s[MAXC];

    // The expected busy and res_valid windows, in negedge cycle numbers.
    int b_lo = -1, b_hi = -2, v_lo = -1, v_hi = -2;
    bit mon_en = 1'b0;

    // The results that the monitor observed at the most recent handshake.
    int obs_rise = 0, obs_fall = 0, obs_ovf = 0;
    int last_rise = -1, last_fall = -1, last_ovf = -1, last_blen = -1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model. A level change between samples k-1 and k is counted in
    // the window only if k+SYNC falls on one of the window edges e0+1 .. e0+n.
    function automatic exp_t model(input int e0, input int n);
        exp_t e;
        int   r = 0;
        int   f = 0;
        for (int k = e0 + 1 - int'(SYNC); k <= e0 + n - int'(SYNC); k++) begin
            if (samp[k] && !samp[k-1]) r++;
            if (!samp[k] && samp[k-1]) f++;
        end
        e.o = (r > CNT_MAX || f > CNT_MAX) ? 1 : 0;
        e.r = (r > CNT_MAX) ? CNT_MAX : r;
        e.f = (f > CNT_MAX) ? CNT_MAX : f;
        return e;
    endfunction

    // q_in pattern generator. i is the number of cycles since the start request.
    function automatic logic q_next(input int mode, input int i, input int n, input logic cur);
        case (mode)
            0:       return cur;
            1:       return ~cur;
            2:       return 1'($urandom_range(0, 1));
            3:       return (i >= 4 && i < 16) ? (((i - 4) % 4) < 2) : 1'b0;
            4:       return (i >= n + 1 - int'(SYNC)) ? 1'b1 : 1'b0;
            6:       return (i >= n - int'(SYNC)) ? 1'b1 : 1'b0;
            default: return ($urandom_range(0, 7) == 0) ? ~cur : cur;
        endcase
    endfunction

    // Edge recorder.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (cyc < MAXC) begin
                samp[cyc]  = rst ? q_in : 1'b0;
                rdy_s[cyc] = res_ready;
            end
        end
    end

    // Monitor.
    initial begin
        bit prev_valid = 1'b0;
        int brun = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_valid = 1'b0;
                brun = 0;
            end else begin
                if (prev_valid && rdy_s[cyc]) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    last_rise = obs_rise;
                    last_fall = obs_fall;
                    last_ovf  = obs_ovf;
                end
                chk("busy", int'(busy), int'(cyc >= b_lo && cyc <= b_hi));
                chk("res_valid", int'(res_valid), int'(cyc >= v_lo && cyc <= v_hi));
                if (res_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result @cyc %0d: got a result, expected none",
                                 cyc);
                    end else begin
                        chk("cnt_rise", int'(cnt_rise), sb[0].r);
                        chk("cnt_fall", int'(cnt_fall), sb[0].f);
                        chk("overflow", int'(overflow), sb[0].o);
                    end
                    obs_rise = int'(cnt_rise);
                    obs_fall = int'(cnt_fall);
                    obs_ovf  = int'(overflow);
                end
                prev_valid = res_valid;
                if (busy) begin
                    brun++;
                end else if (brun != 0) begin
                    last_blen = brun;
                    brun = 0;
                end
            end
        end
    end

    // Issues one window of n cycles with q_in pattern `mode`. The consumer
    // withholds res_ready for `delay` cycles of HOLD. Start and win_len are
    // junk while MEAS and HOLD last, because the DUT must ignore them there.
    task automatic run_txn(input int n, input int mode, input int delay);
        int c, e0, hold, cc;
        @(negedge clk);
        c    = cyc;
        e0   = c + 1;
        hold = e0 + n;
        b_lo = e0;
        b_hi = e0 + n - 1;
        v_lo = hold;
        v_hi = hold + delay;
        start   = 1'b1;
        win_len = WIN_W'(n);
        cc = c;
        while (cc != hold + 1 + delay) begin
            if (cc == hold - 1) sb.push_back(model(e0, n));
            if (cc > c) begin
                start   = 1'($urandom_range(0, 1));
                win_len = WIN_W'($urandom_range(0, 255));
            end
            if (cc >= hold + delay)  res_ready = 1'b1;
            else if (cc >= hold)     res_ready = 1'b0;
            else                     res_ready = 1'($urandom_range(0, 1));
            q_in = q_next(mode, cc - c, n, q_in);
            @(negedge clk);
            cc = cyc;
        end
        start = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet(input int cycles);
        q_in = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n, mode, delay;

        // Reset held for 3 cycles with q_in toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            q_in = ~q_in;
            chk("rst_busy", int'(busy), 0);
            chk("rst_valid", int'(res_valid), 0);
            chk("rst_rise", int'(cnt_rise), 0);
            chk("rst_fall", int'(cnt_fall), 0);
            chk("rst_ovf", int'(overflow), 0);
        end
        q_in = 1'b0;
        #2 rst = 1'b1;
        settle();
        mon_en = 1'b1;
        quiet(6);
        chk("idle_rise", int'(cnt_rise), 0);
        chk("idle_fall", int'(cnt_fall), 0);
        chk("idle_ovf", int'(overflow), 0);

        // Basic count: three 2-high/2-low pulses inside a 40-cycle window.
        quiet(4);
        run_txn(40, 3, 0);
        settle();
        chk("basic_rise", last_rise, 3);
        chk("basic_fall", last_fall, 3);
        chk("basic_ovf", last_ovf, 0);
        chk("basic_busy_len", last_blen, 40);

        // Boundary A: the synchronised edge lands in window cycle 1.
        quiet(4);
        @(negedge clk);
        q_in = 1'b1;
        repeat (int'(SYNC) - 2) @(negedge clk);
        run_txn(10, 0, 0);
        settle();
        chk("edge_first_cycle", last_rise, 1);

        // Boundary: the edge lands in the final window cycle.
        quiet(4);
        run_txn(10, 6, 0);
        settle();
        chk("edge_last_cycle", last_rise, 1);

        // Boundary B: the edge lands one cycle after the window.
        quiet(4);
        run_txn(10, 4, 0);
        settle();
        chk("edge_after_window", last_rise, 0);

        // Boundary C: zero-length window.
        run_txn(0, 2, 0);
        settle();
        chk("zero_win_rise", last_rise, 0);
        chk("zero_win_fall", last_fall, 0);

        // Saturation, then a quiet window that clears overflow.
        quiet(4);
        run_txn(64, 1, 0);
        settle();
        chk("sat_rise", last_rise, CNT_MAX);
        chk("sat_fall", last_fall, CNT_MAX);
        chk("sat_ovf", last_ovf, 1);
        quiet(4);
        run_txn(20, 0, 0);
        settle();
        chk("post_sat_ovf", last_ovf, 0);
        chk("post_sat_rise", last_rise, 0);

        // Backpressure: res_ready withheld for 10 cycles of HOLD.
        run_txn(20, 2, 10);
        settle();

        // Reset asserted in window cycle 10 of 40.
        quiet(4);
        #1 mon_en = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        win_len = WIN_W'(40);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            q_in  = ~q_in;
        end
        chk("mid_busy_before", int'(busy), 1);
        chk("mid_rise_before", int'(cnt_rise), 4);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_valid", int'(res_valid), 0);
        chk("mid_rise", int'(cnt_rise), 0);
        chk("mid_fall", int'(cnt_fall), 0);
        chk("mid_ovf", int'(overflow), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        b_lo = -1; b_hi = -2; v_lo = -1; v_hi = -2;
        quiet(6);
        #1 mon_en = 1'b1;
        run_txn(25, 2, 1);
        settle();

        // Randomised windows.
        for (int t = 0; t < 40; t++) begin
            n     = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 70));
            mode  = int'($urandom_range(0, 5));
            delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_txn(n, mode, delay);
            if ($urandom_range(0, 2) == 0) begin
                res_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end
        settle();
        settle();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tff_edge_meter.md
Name: tff_edge_meter

Overview:
- Downstream consumer of a T flip-flop output.
- Synchronises the toggling q signal into the local clock domain and detects rising and falling edges.
- Counts those edges over a programmable measurement window.
- Presents the counts through a valid/ready result handshake.
- Used to check the toggle rate of the flip-flop stage and to measure its effective division ratio.

Parameters:
- WIN_W, 16, width of window length input and internal window down-counter
- CNT_W, 16, width of each edge counter
- SYNC_STAGES, 2, flops in the q_in synchroniser (legal range 2..4)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low; clears all state when 0
- q_in  input  1  toggle output from the upstream flip-flop; may be asynchronous to clk
- start  input  1  request a measurement; sampled only in IDLE
- win_len  input  WIN_W  window length in clk cycles; latched when start is accepted
- busy  output  1  high while the window is open (MEAS state)
- cnt_rise  output  CNT_W  rising edges counted in the last window
- cnt_fall  output  CNT_W  falling edges counted in the last window
- overflow  output  1  set if either counter saturated during the window
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Synchroniser flops, edge-detect history flop, window counter, cnt_rise, cnt_fall and overflow all go to 0.
  - busy=0 and res_valid=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-window or mid-HOLD discards the result; no partial result is ever presented.
- Synchroniser and edge detection:
  - q_in passes through SYNC_STAGES flops to give q_s; a history flop holds q_s_d.
  - rise = q_s & ~q_s_d; fall = ~q_s & q_s_d.
  - The history flop updates every cycle in every state, so no spurious edge appears at window start.
  - Edge latency: a q_in transition is counted SYNC_STAGES cycles after the first clk edge that samples it.
- FSM states: IDLE, MEAS, HOLD.
- IDLE:
  - busy=0, res_valid=0.
  - On start=1: latch win_len, clear both counters and overflow.
  - If win_len!=0, go to MEAS. If win_len==0, go directly to HOLD with zero counts.
- MEAS:
  - busy=1. The window is exactly win_len cycles, starting the cycle after start is accepted.
  - Each cycle: cnt_rise+=rise, cnt_fall+=fall, window counter decrements.
  - Edges detected in the final window cycle are counted.
  - After the final cycle, go to HOLD. start is ignored.
- Counter arithmetic:
  - Unsigned, CNT_W bits.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - An increment attempted at saturation sets overflow. overflow is sticky until the next accepted start.
- HOLD:
  - res_valid=1; cnt_rise, cnt_fall and overflow are held stable.
  - When res_valid & res_ready at a clk edge: go to IDLE and drop res_valid on the next cycle. Counts remain readable until the next start.
  - start is ignored in HOLD.
  - res_ready may be held permanently high; HOLD then lasts one cycle.
- Simultaneous events:
  - start and res_ready together in HOLD: only the handshake completes. start must be re-asserted in IDLE.
  - An edge in the same cycle as the MEAS-to-HOLD transition belongs to the window only if it falls in the final window cycle.
- Outputs:
  - busy and res_valid are registered, decoded directly from the state register.
  - No combinational path from any input to any output.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst=0 for 3 cycles with q_in toggling.
  - Response: busy=0, res_valid=0, cnt_rise=cnt_fall=0, overflow=0. Outputs stay 0 after release until start.
- Basic count:
  - Stimulus: q_in=0 and stable; start with win_len=40; then drive 3 pulses on q_in (high 2 cycles, low 2 cycles), beginning 4 cycles into the window; res_ready=1.
  - Response: busy high exactly 40 cycles, then res_valid for 1 cycle with cnt_rise=3, cnt_fall=3, overflow=0.
- Boundary edges and zero window:
  - Stimulus A: q_in rises so the synchronised edge lands in window cycle 1.
  - Response A: counted.
  - Stimulus B: q_in rises so the synchronised edge lands one cycle after the last window cycle.
  - Response B: not counted.
  - Stimulus C: win_len=0.
  - Response C: res_valid next cycle, counts 0.
- Saturation:
  - Stimulus: CNT_W=4; q_in toggles every cycle for a 64-cycle window.
  - Response: cnt_rise=cnt_fall=15, overflow=1. The following start with a quiet q_in yields overflow=0.
- Backpressure:
  - Stimulus: res_ready=0 for 10 cycles after HOLD is entered, with start pulsed and q_in toggling meanwhile.
  - Response: results stable, res_valid held high, no new window. With res_ready=1, IDLE follows one cycle later.
- Mid-operation reset:
  - Stimulus: assert rst=0 at window cycle 10 of 40.
  - Response: busy and res_valid fall immediately, counters read 0. A fresh start afterwards measures correctly.
